// File: rtl/tawas_regfile_mt_if.sv
// Port bundle between the Tawas core pipeline and its multi-thread register file.
// The core drives selects and write requests; the register file returns operand data and load-busy flags.
interface tawas_regfile_mt_if #(
  parameter int THREADS = 2,
  parameter int REGS    = 8,
  parameter int DW      = 32,
  parameter int PCW     = 24
);
  localparam int TW = $clog2(THREADS);
  localparam int RW = $clog2(REGS);

  logic [TW-1:0]      THREAD;
  logic               PC_STORE;
  logic [PCW-1:0]     PC;
  logic [PCW-1:0]     PC_RTN;
  logic               RF_IMM_VLD;
  logic [RW-1:0]      RF_IMM_SEL;
  logic [DW-1:0]      RF_IMM;
  logic [RW-1:0]      AU_RA_SEL;
  logic [RW-1:0]      AU_RB_SEL;
  logic [DW-1:0]      AU_RA;
  logic [DW-1:0]      AU_RB;
  logic               AU_RA_BUSY;
  logic               AU_RB_BUSY;
  logic               AU_RC_VLD;
  logic [RW-1:0]      AU_RC_SEL;
  logic [DW-1:0]      AU_RC;
  logic [RW-1:0]      LS_PTR_SEL;
  logic [RW-1:0]      LS_STORE_SEL;
  logic [DW-1:0]      LS_PTR;
  logic [DW-1:0]      LS_STORE;
  logic               LS_PTR_BUSY;
  logic               LS_STORE_BUSY;
  logic               LS_PTR_UPD_VLD;
  logic [RW-1:0]      LS_PTR_UPD_SEL;
  logic [DW-1:0]      LS_PTR_UPD;
  logic               LS_ISSUE_VLD;
  logic [RW-1:0]      LS_ISSUE_SEL;
  logic               LS_LOAD_VLD;
  logic [TW-1:0]      LS_LOAD_THREAD;
  logic [RW-1:0]      LS_LOAD_SEL;
  logic [DW-1:0]      LS_LOAD;
  logic [THREADS-1:0] PEND_ANY;

  modport master (
    output THREAD, PC_STORE, PC, RF_IMM_VLD, RF_IMM_SEL, RF_IMM,
           AU_RA_SEL, AU_RB_SEL, AU_RC_VLD, AU_RC_SEL, AU_RC,
           LS_PTR_SEL, LS_STORE_SEL, LS_PTR_UPD_VLD, LS_PTR_UPD_SEL, LS_PTR_UPD,
           LS_ISSUE_VLD, LS_ISSUE_SEL, LS_LOAD_VLD, LS_LOAD_THREAD, LS_LOAD_SEL, LS_LOAD,
    input  PC_RTN, AU_RA, AU_RB, AU_RA_BUSY, AU_RB_BUSY,
           LS_PTR, LS_STORE, LS_PTR_BUSY, LS_STORE_BUSY, PEND_ANY
  );

  modport slave (
    input  THREAD, PC_STORE, PC, RF_IMM_VLD, RF_IMM_SEL, RF_IMM,
           AU_RA_SEL, AU_RB_SEL, AU_RC_VLD, AU_RC_SEL, AU_RC,
           LS_PTR_SEL, LS_STORE_SEL, LS_PTR_UPD_VLD, LS_PTR_UPD_SEL, LS_PTR_UPD,
           LS_ISSUE_VLD, LS_ISSUE_SEL, LS_LOAD_VLD, LS_LOAD_THREAD, LS_LOAD_SEL, LS_LOAD,
    output PC_RTN, AU_RA, AU_RB, AU_RA_BUSY, AU_RB_BUSY,
           LS_PTR, LS_STORE, LS_PTR_BUSY, LS_STORE_BUSY, PEND_ANY
  );
endinterface

// File: rtl/tawas_regfile_mt.sv
// Multi-thread register file: one bank per hardware thread, each with a pending-load scoreboard.
// Early writes target the issuing thread, late writes the previous one, and load returns carry their own thread tag.
module tawas_regfile_mt_bank #(
  parameter int REGS     = 8,
  parameter int DW       = 32,
  parameter int PCW      = 24,
  parameter int LINK_REG = 6,
  localparam int RW      = $clog2(REGS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      pc_we,
  input  logic [PCW-1:0]            pc,
  input  logic                      imm_we,
  input  logic [RW-1:0]             imm_sel,
  input  logic [DW-1:0]             imm,
  input  logic                      rc_we,
  input  logic [RW-1:0]             rc_sel,
  input  logic [DW-1:0]             rc,
  input  logic                      ptr_we,
  input  logic [RW-1:0]             ptr_sel,
  input  logic [DW-1:0]             ptr,
  input  logic                      ld_we,
  input  logic [RW-1:0]             ld_sel,
  input  logic [DW-1:0]             ld,
  input  logic                      issue,
  input  logic [RW-1:0]             issue_sel,
  output logic [REGS-1:0][DW-1:0]   regs,
  output logic [REGS-1:0]           pend
);
  // Collision priority: load return > pointer update > ALU > immediate > PC link.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs <= '0;
      pend <= '0;
    end else begin
      for (int r = 0; r < REGS; r++) begin
        if (ld_we && ld_sel == RW'(r))          regs[r] <= ld;
        else if (ptr_we && ptr_sel == RW'(r))   regs[r] <= ptr;
        else if (rc_we && rc_sel == RW'(r))     regs[r] <= rc;
        else if (imm_we && imm_sel == RW'(r))   regs[r] <= imm;
        else if (pc_we && r == LINK_REG)        regs[r] <= DW'(pc);
        // A fresh issue keeps the bit set even if an older load returns the same cycle.
        if (issue && issue_sel == RW'(r))       pend[r] <= 1'b1;
        else if (ld_we && ld_sel == RW'(r))     pend[r] <= 1'b0;
      end
    end
  end
endmodule

module tawas_regfile_mt #(
  parameter int THREADS  = 2,
  parameter int REGS     = 8,
  parameter int DW       = 32,
  parameter int PCW      = 24,
  parameter int LINK_REG = 6
) (
  input logic CLK,
  input logic RST,
  tawas_regfile_mt_if.slave bus
);
  localparam int TW = $clog2(THREADS);

  logic [THREADS-1:0][REGS-1:0][DW-1:0] rf;
  logic [THREADS-1:0][REGS-1:0]         pend;
  logic [TW-1:0]                        prev;

  // THREADS is a power of 2, so plain TW-bit subtraction wraps 0 to THREADS-1.
  assign prev = bus.THREAD - TW'(1);

  for (genvar t = 0; t < THREADS; t++) begin : g_bank
    logic cur, prv;
    assign cur = (bus.THREAD == TW'(t));
    assign prv = (prev == TW'(t));

    tawas_regfile_mt_bank #(
      .REGS(REGS), .DW(DW), .PCW(PCW), .LINK_REG(LINK_REG)
    ) u_bank (
      .CLK       (CLK),
      .RST       (RST),
      .pc_we     (bus.PC_STORE & cur),
      .pc        (bus.PC),
      .imm_we    (bus.RF_IMM_VLD & cur),
      .imm_sel   (bus.RF_IMM_SEL),
      .imm       (bus.RF_IMM),
      .rc_we     (bus.AU_RC_VLD & prv),
      .rc_sel    (bus.AU_RC_SEL),
      .rc        (bus.AU_RC),
      .ptr_we    (bus.LS_PTR_UPD_VLD & prv),
      .ptr_sel   (bus.LS_PTR_UPD_SEL),
      .ptr       (bus.LS_PTR_UPD),
      .ld_we     (bus.LS_LOAD_VLD & (bus.LS_LOAD_THREAD == TW'(t))),
      .ld_sel    (bus.LS_LOAD_SEL),
      .ld        (bus.LS_LOAD),
      .issue     (bus.LS_ISSUE_VLD & prv),
      .issue_sel (bus.LS_ISSUE_SEL),
      .regs      (rf[t]),
      .pend      (pend[t])
    );

    assign bus.PEND_ANY[t] = |pend[t];
  end

  assign bus.AU_RA         = rf[bus.THREAD][bus.AU_RA_SEL];
  assign bus.AU_RB         = rf[bus.THREAD][bus.AU_RB_SEL];
  assign bus.LS_PTR        = rf[bus.THREAD][bus.LS_PTR_SEL];
  assign bus.LS_STORE      = rf[bus.THREAD][bus.LS_STORE_SEL];
  assign bus.PC_RTN        = rf[bus.THREAD][LINK_REG][PCW-1:0];
  assign bus.AU_RA_BUSY    = pend[bus.THREAD][bus.AU_RA_SEL];
  assign bus.AU_RB_BUSY    = pend[bus.THREAD][bus.AU_RB_SEL];
  assign bus.LS_PTR_BUSY   = pend[bus.THREAD][bus.LS_PTR_SEL];
  assign bus.LS_STORE_BUSY = pend[bus.THREAD][bus.LS_STORE_SEL];
endmodule

// File: tb/tb_tawas_regfile_mt.sv
// Directed bench for tawas_regfile_mt with four threads: write routing, collision priority,
// thread wrap, pending-load scoreboard and asynchronous reset.
module tb_tawas_regfile_mt;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tawas_regfile_mt_if #(.THREADS(4), .REGS(8), .DW(32), .PCW(24)) bus ();

  tawas_regfile_mt #(.THREADS(4), .REGS(8), .DW(32), .PCW(24), .LINK_REG(6)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    bus.PC_STORE = 0; bus.PC = '0;
    bus.RF_IMM_VLD = 0; bus.RF_IMM_SEL = '0; bus.RF_IMM = '0;
    bus.AU_RC_VLD = 0; bus.AU_RC_SEL = '0; bus.AU_RC = '0;
    bus.LS_PTR_UPD_VLD = 0; bus.LS_PTR_UPD_SEL = '0; bus.LS_PTR_UPD = '0;
    bus.LS_ISSUE_VLD = 0; bus.LS_ISSUE_SEL = '0;
    bus.LS_LOAD_VLD = 0; bus.LS_LOAD_THREAD = '0; bus.LS_LOAD_SEL = '0; bus.LS_LOAD = '0;
  endtask

  // Apply the staged writes on one rising edge, then return to a quiet bus just after it.
  task automatic tick();
    @(posedge CLK); #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    bus.THREAD = '0; bus.AU_RA_SEL = '0; bus.AU_RB_SEL = '0; bus.LS_PTR_SEL = '0; bus.LS_STORE_SEL = '0;
    RST = 1'b1;
    #3;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 8; r++) begin
        bus.THREAD = 2'(t);
        bus.AU_RA_SEL = 3'(r); bus.AU_RB_SEL = 3'(r); bus.LS_PTR_SEL = 3'(r); bus.LS_STORE_SEL = 3'(r);
        #1;
        checks++;
        if ({bus.AU_RA, bus.AU_RB, bus.LS_PTR, bus.LS_STORE} !== 128'h0) begin
          errors++; $display("FAIL reset_data t=%0d r=%0d got %h %h %h %h want 0", t, r, bus.AU_RA, bus.AU_RB, bus.LS_PTR, bus.LS_STORE);
        end
        checks++;
        if ({bus.AU_RA_BUSY, bus.AU_RB_BUSY, bus.LS_PTR_BUSY, bus.LS_STORE_BUSY} !== 4'b0) begin
          errors++; $display("FAIL reset_busy t=%0d r=%0d got %b want 0000", t, r, {bus.AU_RA_BUSY, bus.AU_RB_BUSY, bus.LS_PTR_BUSY, bus.LS_STORE_BUSY});
        end
      end
    end
    checks++;
    if (bus.PEND_ANY !== 4'b0 || bus.PC_RTN !== 24'h0) begin
      errors++; $display("FAIL reset_pend got pend=%b pc_rtn=%h want 0 0", bus.PEND_ANY, bus.PC_RTN);
    end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_imm();
    bus.THREAD = 2; bus.RF_IMM_VLD = 1; bus.RF_IMM_SEL = 3; bus.RF_IMM = 32'h11223344;
    tick();
    bus.THREAD = 2; bus.AU_RA_SEL = 3; #1;
    checks++;
    if (bus.AU_RA !== 32'h11223344) begin
      errors++; $display("FAIL imm_write got %h want 11223344", bus.AU_RA);
    end
    for (int t = 0; t < 4; t++) begin
      if (t == 2) continue;
      bus.THREAD = 2'(t); bus.AU_RB_SEL = 3; #1;
      checks++;
      if (bus.AU_RB !== 32'h0) begin
        errors++; $display("FAIL imm_isolation t=%0d got %h want 0", t, bus.AU_RB);
      end
    end
  endtask

  task automatic test_wrap();
    bus.THREAD = 0; bus.AU_RC_VLD = 1; bus.AU_RC_SEL = 1; bus.AU_RC = 32'hA5A5A5A5;
    tick();
    bus.THREAD = 3; bus.AU_RA_SEL = 1; #1;
    checks++;
    if (bus.AU_RA !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL wrap_t3 got %h want a5a5a5a5", bus.AU_RA);
    end
    bus.THREAD = 0; #1;
    checks++;
    if (bus.AU_RA !== 32'h0) begin
      errors++; $display("FAIL wrap_t0 got %h want 0", bus.AU_RA);
    end
  endtask

  task automatic test_collision();
    bus.THREAD = 1; bus.PC_STORE = 1; bus.PC = 24'h123456;
    bus.AU_RC_VLD = 1; bus.AU_RC_SEL = 6; bus.AU_RC = 32'hDEAD;
    bus.RF_IMM_VLD = 1; bus.RF_IMM_SEL = 6; bus.RF_IMM = 32'hBEEF;
    tick();
    bus.THREAD = 1; bus.AU_RA_SEL = 6; #1;
    checks++;
    if (bus.AU_RA !== 32'hBEEF || bus.PC_RTN !== 24'h00BEEF) begin
      errors++; $display("FAIL imm_over_pc got %h pc_rtn=%h want 0000beef 00beef", bus.AU_RA, bus.PC_RTN);
    end
    bus.THREAD = 0; #1;
    checks++;
    if (bus.AU_RA !== 32'hDEAD) begin
      errors++; $display("FAIL rc_prev got %h want 0000dead", bus.AU_RA);
    end
    // Lone PC_STORE: zero-extended into the link register.
    bus.THREAD = 3; bus.PC_STORE = 1; bus.PC = 24'hABCDEF;
    tick();
    bus.THREAD = 3; bus.LS_STORE_SEL = 6; #1;
    checks++;
    if (bus.PC_RTN !== 24'hABCDEF || bus.LS_STORE !== 32'h00ABCDEF) begin
      errors++; $display("FAIL pc_store got pc_rtn=%h reg=%h want abcdef 00abcdef", bus.PC_RTN, bus.LS_STORE);
    end
    // Load > pointer update > ALU, all on thread 0 reg 4.
    bus.THREAD = 1;
    bus.LS_PTR_UPD_VLD = 1; bus.LS_PTR_UPD_SEL = 4; bus.LS_PTR_UPD = 32'h1111;
    bus.AU_RC_VLD = 1; bus.AU_RC_SEL = 4; bus.AU_RC = 32'h2222;
    bus.LS_LOAD_VLD = 1; bus.LS_LOAD_THREAD = 0; bus.LS_LOAD_SEL = 4; bus.LS_LOAD = 32'h3333;
    tick();
    bus.THREAD = 0; bus.LS_PTR_SEL = 4; #1;
    checks++;
    if (bus.LS_PTR !== 32'h3333) begin
      errors++; $display("FAIL load_over_ptr got %h want 00003333", bus.LS_PTR);
    end
    bus.THREAD = 1;
    bus.LS_PTR_UPD_VLD = 1; bus.LS_PTR_UPD_SEL = 7; bus.LS_PTR_UPD = 32'h4444;
    bus.AU_RC_VLD = 1; bus.AU_RC_SEL = 7; bus.AU_RC = 32'h5555;
    tick();
    bus.THREAD = 0; bus.LS_PTR_SEL = 7; #1;
    checks++;
    if (bus.LS_PTR !== 32'h4444) begin
      errors++; $display("FAIL ptr_over_rc got %h want 00004444", bus.LS_PTR);
    end
  endtask

  task automatic test_scoreboard();
    bus.THREAD = 1; bus.LS_ISSUE_VLD = 1; bus.LS_ISSUE_SEL = 5;
    tick();
    bus.THREAD = 0; bus.LS_PTR_SEL = 5; bus.LS_STORE_SEL = 5; #1;
    checks++;
    if (bus.LS_PTR_BUSY !== 1'b1 || bus.LS_STORE_BUSY !== 1'b1 || bus.PEND_ANY !== 4'b0001) begin
      errors++; $display("FAIL issue_busy got busy=%b%b pend=%b want 11 0001", bus.LS_PTR_BUSY, bus.LS_STORE_BUSY, bus.PEND_ANY);
    end
    bus.LS_LOAD_VLD = 1; bus.LS_LOAD_THREAD = 0; bus.LS_LOAD_SEL = 5; bus.LS_LOAD = 32'h77;
    tick();
    bus.THREAD = 0; bus.LS_PTR_SEL = 5; #1;
    checks++;
    if (bus.LS_PTR_BUSY !== 1'b0 || bus.LS_PTR !== 32'h77 || bus.PEND_ANY !== 4'b0) begin
      errors++; $display("FAIL load_return got busy=%b data=%h pend=%b want 0 00000077 0000", bus.LS_PTR_BUSY, bus.LS_PTR, bus.PEND_ANY);
    end
    // Issue and return on thread 0 reg 2 in one cycle: data lands, bit stays set.
    bus.THREAD = 1; bus.LS_ISSUE_VLD = 1; bus.LS_ISSUE_SEL = 2;
    bus.LS_LOAD_VLD = 1; bus.LS_LOAD_THREAD = 0; bus.LS_LOAD_SEL = 2; bus.LS_LOAD = 32'h99;
    tick();
    bus.THREAD = 0; bus.AU_RB_SEL = 2; #1;
    checks++;
    if (bus.AU_RB !== 32'h99 || bus.AU_RB_BUSY !== 1'b1) begin
      errors++; $display("FAIL issue_and_return got %h busy=%b want 00000099 1", bus.AU_RB, bus.AU_RB_BUSY);
    end
    // Re-issue and an ALU write leave the bit set; a single return then clears it.
    bus.THREAD = 1; bus.LS_ISSUE_VLD = 1; bus.LS_ISSUE_SEL = 2;
    tick();
    bus.THREAD = 1; bus.AU_RC_VLD = 1; bus.AU_RC_SEL = 2; bus.AU_RC = 32'hABAB;
    tick();
    bus.THREAD = 0; bus.AU_RB_SEL = 2; #1;
    checks++;
    if (bus.AU_RB !== 32'hABAB || bus.AU_RB_BUSY !== 1'b1) begin
      errors++; $display("FAIL rc_keeps_pend got %h busy=%b want 0000abab 1", bus.AU_RB, bus.AU_RB_BUSY);
    end
    bus.LS_LOAD_VLD = 1; bus.LS_LOAD_THREAD = 0; bus.LS_LOAD_SEL = 2; bus.LS_LOAD = 32'h1234;
    tick();
    bus.THREAD = 0; bus.AU_RB_SEL = 2; #1;
    checks++;
    if (bus.AU_RB_BUSY !== 1'b0 || bus.PEND_ANY !== 4'b0) begin
      errors++; $display("FAIL no_counting got busy=%b pend=%b want 0 0000", bus.AU_RB_BUSY, bus.PEND_ANY);
    end
    // Return to a register that was never pending.
    bus.LS_LOAD_VLD = 1; bus.LS_LOAD_THREAD = 2; bus.LS_LOAD_SEL = 0; bus.LS_LOAD = 32'h55;
    tick();
    bus.THREAD = 2; bus.AU_RA_SEL = 0; #1;
    checks++;
    if (bus.AU_RA !== 32'h55 || bus.AU_RA_BUSY !== 1'b0 || bus.PEND_ANY !== 4'b0) begin
      errors++; $display("FAIL stray_return got %h busy=%b pend=%b want 00000055 0 0000", bus.AU_RA, bus.AU_RA_BUSY, bus.PEND_ANY);
    end
  endtask

  task automatic test_reset_mid();
    bus.THREAD = 0; bus.LS_ISSUE_VLD = 1; bus.LS_ISSUE_SEL = 1;
    tick();
    #1;
    checks++;
    if (bus.PEND_ANY !== 4'b1000) begin
      errors++; $display("FAIL pend_t3 got %b want 1000", bus.PEND_ANY);
    end
    RST = 1'b1; #1;
    bus.THREAD = 2; bus.AU_RA_SEL = 3; #1;
    checks++;
    if (bus.PEND_ANY !== 4'b0 || bus.AU_RA !== 32'h0) begin
      errors++; $display("FAIL async_reset got pend=%b data=%h want 0000 0", bus.PEND_ANY, bus.AU_RA);
    end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    bus.LS_LOAD_VLD = 1; bus.LS_LOAD_THREAD = 3; bus.LS_LOAD_SEL = 1; bus.LS_LOAD = 32'hCAFE;
    tick();
    bus.THREAD = 3; bus.AU_RA_SEL = 1; #1;
    checks++;
    if (bus.AU_RA !== 32'hCAFE || bus.AU_RA_BUSY !== 1'b0 || bus.PEND_ANY !== 4'b0) begin
      errors++; $display("FAIL load_after_reset got %h busy=%b pend=%b want 0000cafe 0 0000", bus.AU_RA, bus.AU_RA_BUSY, bus.PEND_ANY);
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_wrap();
    test_collision();
    test_scoreboard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tawas_regfile_mt.md
Name: tawas_regfile_mt

Overview:
- Multi-thread register file for the Tawas core.
- Holds THREADS independent banks of REGS x DW registers. Early writes (PC link, immediate) go to the current thread; late writes (ALU result, pointer update) go to the previous thread in round-robin order.
- Load data returns with an explicit thread tag.
- A per-register pending-load scoreboard flags read operands whose load has not returned, so decode can stall.

Parameters:
- THREADS, 2, number of hardware threads/banks; power of 2, 2..8; TW = clog2(THREADS).
- REGS, 8, registers per thread; power of 2, 8..16; RW = clog2(REGS).
- DW, 32, register data width.
- PCW, 24, program counter width; PCW <= DW.
- LINK_REG, 6, register index written by PC_STORE; must be < REGS.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- THREAD  in  TW  current issuing thread; advances round-robin, +1 mod THREADS per cycle.
- PC_STORE  in  1  write {0, PC} to LINK_REG of THREAD.
- PC  in  PCW  return address.
- PC_RTN  out  PCW  LINK_REG[PCW-1:0] of THREAD.
- RF_IMM_VLD / RF_IMM_SEL / RF_IMM  in  1/RW/DW  immediate write to THREAD.
- AU_RA_SEL, AU_RB_SEL  in  RW  ALU operand selects for THREAD.
- AU_RA, AU_RB  out  DW  ALU operand data.
- AU_RA_BUSY, AU_RB_BUSY  out  1  selected operand has a load pending.
- AU_RC_VLD / AU_RC_SEL / AU_RC  in  1/RW/DW  ALU writeback to thread PREV = THREAD-1 mod THREADS.
- LS_PTR_SEL, LS_STORE_SEL  in  RW  load/store pointer and store-data selects for THREAD.
- LS_PTR, LS_STORE  out  DW  pointer and store data.
- LS_PTR_BUSY, LS_STORE_BUSY  out  1  load pending on the selected register.
- LS_PTR_UPD_VLD / LS_PTR_UPD_SEL / LS_PTR_UPD  in  1/RW/DW  pointer writeback to PREV.
- LS_ISSUE_VLD / LS_ISSUE_SEL  in  1/RW  load issued by PREV; marks destination pending.
- LS_LOAD_VLD / LS_LOAD_THREAD / LS_LOAD_SEL / LS_LOAD  in  1/TW/RW/DW  load return.
- PEND_ANY  out  THREADS  per-thread OR of pending bits.

Behaviour:
- Reset: all registers 0; all pending bits 0. Outputs are combinational from state and selects, so all data outputs read 0, all BUSY outputs read 0, PEND_ANY = 0.
- Reads: combinational, from the bank selected by THREAD; no internal bypass. A write becomes visible the cycle after its CLK edge.
- Writes: registered on the CLK edge.
- PC_STORE writes zero-extended PC to LINK_REG of THREAD.
- Same-register write collision, priority from highest to lowest:
  - LS_LOAD
  - LS_PTR_UPD
  - AU_RC
  - RF_IMM
  - PC_STORE
- Different registers or different threads write independently in the same cycle.
- Wrap-around: THREAD = 0 gives PREV = THREADS-1.
- Scoreboard:
  - LS_ISSUE_VLD sets pend[PREV][LS_ISSUE_SEL].
  - LS_LOAD_VLD clears pend[LS_LOAD_THREAD][LS_LOAD_SEL] and writes the data.
  - Issue and return on the same thread/register in the same cycle: the data is written and the pending bit ends set (set wins; the new load is still outstanding).
  - Issue to an already-pending register: stays set; no counting.
  - Return to a non-pending register: data written, bit stays 0, no error.
- BUSY = pend[THREAD][sel], combinational.
- Writes by AU_RC or LS_PTR_UPD do not modify pending bits.
- RST asserted mid-operation clears everything immediately. A load returning after reset deasserts writes normally.
- Out-of-range selects cannot occur because REGS is a power of 2.

Test Plan:
- Reset, then read all threads/registers -> every read = 0, every BUSY = 0, PEND_ANY = 0.
- THREADS=4; THREAD=2, RF_IMM_VLD with sel 3, data 0x11223344 -> next cycle with THREAD=2, AU_RA_SEL=3 reads 0x11223344; threads 0, 1, 3 reg 3 still read 0.
- THREAD=0, AU_RC_VLD with sel 1, data 0xA5A5A5A5 -> written to thread 3 (wrap), not thread 0.
- THREAD=1, same cycle: PC_STORE with PC 0x123456, AU_RC to PREV=0 reg 6 with 0xDEAD, RF_IMM to thread 1 reg 6 with 0xBEEF -> thread 1 reg 6 = 0xBEEF (RF_IMM beats PC_STORE); thread 0 reg 6 = 0xDEAD.
- LS_PTR_UPD and LS_LOAD to the same thread/register in one cycle -> load data wins.
- THREAD=1, LS_ISSUE with sel 5 -> at THREAD=0, LS_PTR_SEL=5 shows LS_PTR_BUSY=1 and PEND_ANY[0]=1; LS_LOAD with thread 0, sel 5, data 0x77 -> next cycle BUSY=0 and LS_PTR=0x77.
- Simultaneous issue and return on thread 0 reg 2 -> reg 2 = return data, BUSY stays 1.
- Assert RST with pending bits set -> all pending bits and registers 0 immediately.
